// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, packed command layout, FSM states.
package alu_seq_pkg;

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned RES_W  = 6;
    localparam int unsigned A_LSB  = 0;
    localparam int unsigned B_LSB  = 3;
    localparam int unsigned OP_LSB = 6;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int unsigned ERR_DIV0 = 0;
    localparam int unsigned ERR_ECHO = 1;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] b;
        logic [2:0] a;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } seq_state_t;

    function automatic alu_cmd_t pack_cmd(input logic [1:0] op, input logic [2:0] a,
                                          input logic [2:0] b);
        alu_cmd_t c;
        c.op = op;
        c.b  = b;
        c.a  = a;
        return c;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry a wrap bit.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers host ALU operations, issues them one at a time to the ALU and returns checked results.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ALU_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_a,
    input  logic [2:0] cmd_b,
    output logic [7:0] alu_cmd,
    output logic       alu_ena,
    input  logic [7:0] alu_res,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [5:0] res_data,
    output logic [1:0] res_op,
    output logic [1:0] res_err,
    output logic       busy,
    output logic [7:0] done_cnt
);

    localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    seq_state_t       state;
    logic [1:0]       op_q;
    logic [LAT_W-1:0] wait_cnt;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CMD_W-1:0] fifo_rdata;
    alu_cmd_t         head;

    assign head      = alu_cmd_t'(fifo_rdata);
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;
    assign busy      = (state != S_IDLE) || !fifo_empty;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata (pack_cmd(cmd_op, cmd_a, cmd_b)),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencer FSM; one operation in flight, outputs registered on state transitions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            wait_cnt  <= '0;
            alu_cmd   <= '0;
            alu_ena   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_err   <= '0;
            done_cnt  <= '0;
        end else begin
            alu_ena <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        op_q <= head.op;
                        if (head.op == OP_DIV && head.b == 3'd0) begin
                            // Divide by zero is answered locally without touching the ALU.
                            res_valid         <= 1'b1;
                            res_data          <= '0;
                            res_op            <= OP_DIV;
                            res_err           <= '0;
                            res_err[ERR_DIV0] <= 1'b1;
                            state             <= S_RESP;
                        end else begin
                            alu_cmd <= head;
                            alu_ena <= 1'b1;
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == LAT_W'(ALU_LAT - 1)) begin
                        res_valid         <= 1'b1;
                        res_data          <= alu_res[RES_W-1:0];
                        res_op            <= op_q;
                        res_err[ERR_DIV0] <= 1'b0;
                        res_err[ERR_ECHO] <= (alu_res[7:6] != op_q);
                        state             <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        done_cnt  <= done_cnt + 8'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural 1-cycle ALU.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [2:0] cmd_a = '0;
    logic [2:0] cmd_b = '0;
    logic [7:0] alu_cmd;
    logic       alu_ena;
    logic [7:0] alu_res = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [5:0] res_data;
    logic [1:0] res_op;
    logic [1:0] res_err;
    logic       busy;
    logic [7:0] done_cnt;

    logic       echo_flip = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_cmd   (alu_cmd),
        .alu_ena   (alu_ena),
        .alu_res   (alu_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_err   (res_err),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] c, input logic flip);
        logic [1:0] op;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] r;
        op = c[7:6];
        a  = 6'(c[2:0]);
        b  = 6'(c[5:3]);
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a * b;
            default: r = (b == 6'd0) ? 6'd0 : a / b;
        endcase
        return {flip ? ~op : op, r};
    endfunction

    // ALU result valid one cycle after the enable edge.
    always_ff @(posedge clk) begin
        if (alu_ena) alu_res <= alu_fn(alu_cmd, echo_flip);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [5:0] data, input logic [1:0] op,
                           input logic [1:0] err);
        int n = 0;
        while (!res_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_data"}, 32'(res_data), 32'(data));
        check({tag, "_op"}, 32'(res_op), 32'(op));
        check({tag, "_err"}, 32'(res_err), 32'(err));
        step();
    endtask

    logic [1:0] t_op [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    logic [2:0] t_a  [8] = '{3'd1, 3'd2, 3'd7, 3'd3, 3'd6, 3'd1, 3'd1, 3'd1};
    logic [2:0] t_b  [8] = '{3'd1, 3'd3, 3'd3, 3'd4, 3'd3, 3'd1, 3'd1, 3'd1};

    initial begin
        int accepted;
        int stale;
        bit stop;

        // Reset state
        do_reset();
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done_cnt), 32'd0);
        check("rst_alucmd", 32'(alu_cmd), 32'd0);
        check("rst_ena", 32'(alu_ena), 32'd0);

        // Test 1: add 3+5, exact cycle timing
        res_ready = 1'b1;
        push(2'b00, 3'd3, 3'd5);
        check("t1_c1_ena", 32'(alu_ena), 32'd0);
        check("t1_c1_busy", 32'(busy), 32'd1);
        step();
        check("t1_c2_ena", 32'(alu_ena), 32'd1);
        check("t1_c2_cmd", 32'(alu_cmd), 32'h2B);
        step();
        check("t1_c3_ena", 32'(alu_ena), 32'd0);
        check("t1_c3_valid", 32'(res_valid), 32'd0);
        step();
        check("t1_c4_valid", 32'(res_valid), 32'd1);
        check("t1_c4_data", 32'(res_data), 32'd8);
        check("t1_c4_err", 32'(res_err), 32'd0);
        check("t1_c4_op", 32'(res_op), 32'd0);
        step();
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_cmd_hold", 32'(alu_cmd), 32'h2B);

        // Test 2: sub/mul/div back to back
        do_reset();
        res_ready = 1'b1;
        push(2'b01, 3'd1, 3'd2);
        push(2'b10, 3'd7, 3'd7);
        push(2'b11, 3'd7, 3'd2);
        collect("t2_sub", 6'd63, 2'b01, 2'b00);
        collect("t2_mul", 6'd49, 2'b10, 2'b00);
        collect("t2_div", 6'd3, 2'b11, 2'b00);
        check("t2_done", 32'(done_cnt), 32'd3);

        // Test 3: divide by zero, no ALU access
        do_reset();
        res_ready = 1'b1;
        push(2'b11, 3'd5, 3'd0);
        check("t3_c1_valid", 32'(res_valid), 32'd0);
        check("t3_c1_ena", 32'(alu_ena), 32'd0);
        step();
        check("t3_c2_valid", 32'(res_valid), 32'd1);
        check("t3_c2_data", 32'(res_data), 32'd0);
        check("t3_c2_err", 32'(res_err), 32'd1);
        check("t3_c2_op", 32'(res_op), 32'd3);
        check("t3_c2_ena", 32'(alu_ena), 32'd0);
        check("t3_alucmd", 32'(alu_cmd), 32'd0);
        step();
        check("t3_done", 32'(done_cnt), 32'd1);

        // Test 4: backpressure fills FIFO plus the op register
        do_reset();
        res_ready = 1'b0;
        accepted  = 0;
        stop      = 1'b0;
        for (int i = 0; i < 12 && !stop; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = t_op[accepted];
            cmd_a     = t_a[accepted];
            cmd_b     = t_b[accepted];
            if (!cmd_ready || accepted >= 7) begin
                stop = 1'b1;
            end else begin
                accepted++;
                step();
            end
        end
        cmd_valid = 1'b0;
        check("t4_accepted", 32'(accepted), 32'd5);
        check("t4_ready_low", 32'(cmd_ready), 32'd0);
        check("t4_hold_valid", 32'(res_valid), 32'd1);
        check("t4_hold_data", 32'(res_data), 32'd2);
        res_ready = 1'b1;
        collect("t4_r0", 6'd2, 2'b00, 2'b00);
        collect("t4_r1", 6'd5, 2'b00, 2'b00);
        collect("t4_r2", 6'd4, 2'b01, 2'b00);
        collect("t4_r3", 6'd12, 2'b10, 2'b00);
        collect("t4_r4", 6'd2, 2'b11, 2'b00);
        check("t4_ready", 32'(cmd_ready), 32'd1);
        check("t4_done", 32'(done_cnt), 32'd5);

        // Test 5: opcode echo mismatch
        do_reset();
        res_ready = 1'b1;
        echo_flip = 1'b1;
        push(2'b00, 3'd2, 3'd2);
        collect("t5_echo", 6'd4, 2'b00, 2'b10);
        echo_flip = 1'b0;

        // Test 6: reset while waiting on the ALU with two entries queued
        do_reset();
        res_ready = 1'b1;
        push(2'b10, 3'd7, 3'd7);
        push(2'b00, 3'd1, 3'd1);
        push(2'b00, 3'd2, 3'd2);
        check("t6_pre_busy", 32'(busy), 32'd1);
        check("t6_pre_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_valid", 32'(res_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(cmd_ready), 32'd1);
        check("t6_done", 32'(done_cnt), 32'd0);
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid || alu_ena) stale++;
            step();
        end
        check("t6_no_stale", 32'(stale), 32'd0);
        check("t6_done_end", 32'(done_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
